// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer: loads a WIDTH-bit word over valid/ready and shifts it
// out LSB first, each bit held for DIV clocks, followed by a one-cycle done.
// Optional feature macro: TX_PARITY_EN (appends an even-parity bit period).
module serial_tx_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_tx_sequencer: WIDTH must be >= 2");
        end
        if (DIV < 1) begin : g_bad_div
            $error("serial_tx_sequencer: DIV must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef TX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
`ifdef TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic period_end;
    assign period_end = (div_cnt_q == DIV_LAST);

    // State and datapath registers; async reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
`ifdef TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
`ifdef TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Next-state and datapath update: load on accept, count bit periods, shift.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
`ifdef TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
`ifdef TX_PARITY_EN
                    par_d     = ^in_data;
`endif
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (period_end) begin
                    div_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (period_end) begin
                    div_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only; in_valid never reaches them.
    always_comb begin
        in_ready = 1'b0;
        ser_out  = 1'b0;
        ser_en   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_SHIFT: begin
                ser_out = shreg_q[0];
                ser_en  = (div_cnt_q == '0);
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                ser_out = par_q;
                ser_en  = (div_cnt_q == '0);
            end
`endif
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Directed bench for serial_tx_sequencer: DIV=1 instance (a) and DIV=3
// instance (b), both WIDTH=8. Parity expectations follow TX_PARITY_EN.
module tb_serial_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TX_PARITY_EN
    localparam int NBITS = 9;
    localparam int NV    = 11;
`else
    localparam int NBITS = 8;
    localparam int NV    = 10;
`endif

    logic       a_rst, a_valid, a_rdy, a_so, a_se, a_bz, a_dn;
    logic [7:0] a_data;
    logic       b_rst, b_valid, b_rdy, b_so, b_se, b_bz, b_dn;
    logic [7:0] b_data;

    int checks = 0;
    int errors = 0;

    serial_tx_sequencer #(.WIDTH(8), .DIV(1)) dut_a (
        .clk(clk), .rst(a_rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_rdy), .ser_out(a_so), .ser_en(a_se), .busy(a_bz), .done(a_dn)
    );

    serial_tx_sequencer #(.WIDTH(8), .DIV(3)) dut_b (
        .clk(clk), .rst(b_rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_rdy), .ser_out(b_so), .ser_en(b_se), .busy(b_bz), .done(b_dn)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       so, se, bz, dn, rdy;
    } vec_t;

    vec_t tv [NV];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_out(input int which, input string tag,
                             input logic so, input logic se, input logic bz,
                             input logic dn, input logic rdy);
        logic [4:0] o;
        o = (which == 0) ? {a_so, a_se, a_bz, a_dn, a_rdy}
                         : {b_so, b_se, b_bz, b_dn, b_rdy};
        chk({tag, " ser_out"},  o[4], so);
        chk({tag, " ser_en"},   o[3], se);
        chk({tag, " busy"},     o[2], bz);
        chk({tag, " done"},     o[1], dn);
        chk({tag, " in_ready"}, o[0], rdy);
    endtask

    task automatic drive(input int which, input logic valid, input logic [7:0] data);
        if (which == 0) begin
            a_valid = valid;
            a_data  = data;
        end else begin
            b_valid = valid;
            b_data  = data;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Entered at cycle 1 after the accept edge; returns while in the done cycle.
    task automatic check_frame(input int which, input int div,
                               input logic [7:0] data, input string tag);
        int   last;
        int   bi;
        logic eso;
        last = NBITS * div + 1;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            if (c < last) begin
                bi  = (c - 1) / div;
                eso = (bi < 8) ? data[bi] : ^data;
                check_out(which, $sformatf("%s c%0d", tag, c),
                          eso, ((c - 1) % div) == 0, 1'b1, 1'b0, 1'b0);
            end else begin
                check_out(which, $sformatf("%s c%0d", tag, c),
                          1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0x0D at DIV=1: bits 1,0,1,1,0,0,0,0 (parity 1 when enabled)
        tv[0] = '{1'b1, 8'h0D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 8'h0D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 8'h0D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 8'h0D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 8'h0D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 8'h0D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[6] = '{1'b0, 8'h0D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[7] = '{1'b0, 8'h0D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef TX_PARITY_EN
        tv[8]  = '{1'b0, 8'h0D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        tv[8]  = '{1'b0, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

        a_rst = 1'b0; b_rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) step();
        check_out(0, "reset_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out(1, "reset_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;
        step();
        check_out(0, "idle_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out(1, "idle_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Table: single 0x0D frame at DIV=1, in_valid pulsed for one cycle
        for (int i = 0; i < NV; i++) begin
            drive(0, tv[i].valid, tv[i].data);
            step();
            check_out(0, $sformatf("tbl c%0d", i + 1),
                      tv[i].so, tv[i].se, tv[i].bz, tv[i].dn, tv[i].rdy);
        end

        // DIV=3 frame of 0xA5
        drive(1, 1'b1, 8'hA5);
        step();
        drive(1, 1'b0, 8'h00);
        check_frame(1, 3, 8'hA5, "div3");
        step();
        check_out(1, "div3 after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back with in_valid held; in_data changes mid-frame
        drive(0, 1'b1, 8'h01);
        step();
        drive(0, 1'b1, 8'h80);
        check_frame(0, 1, 8'h01, "b2b1");
        step();
        check_out(0, "b2b gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(0, 1'b0, 8'h00);
        check_frame(0, 1, 8'h80, "b2b2");
        step();
        check_out(0, "b2b end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset asserted during the 4th bit of 0xFF
        drive(0, 1'b1, 8'hFF);
        step();
        drive(0, 1'b0, 8'h00);
        repeat (3) step();
        check_out(0, "pre_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        a_rst = 1'b0;
        #1;
        chk("midrst ser_out", a_so, 1'b0);
        chk("midrst ser_en",  a_se, 1'b0);
        chk("midrst busy",    a_bz, 1'b0);
        chk("midrst done",    a_dn, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("inrst%0d done", i), a_dn, 1'b0);
            chk($sformatf("inrst%0d busy", i), a_bz, 1'b0);
        end
        @(negedge clk);
        a_rst = 1'b1;
        step();
        check_out(0, "postrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 8'h03);
        step();
        drive(0, 1'b0, 8'h00);
        check_frame(0, 1, 8'h03, "x03");
        step();
        check_out(0, "x03 after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // in_valid with 0x55 while busy on 0x0F (DIV=3) is held off
        drive(1, 1'b1, 8'h0F);
        step();
        drive(1, 1'b1, 8'h55);
        check_frame(1, 3, 8'h0F, "busy0F");
        step();
        check_out(1, "busy gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1, 1'b0, 8'h00);
        check_frame(1, 3, 8'h55, "late55");
        step();
        check_out(1, "late55 after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_sequencer.md
Name: serial_tx_sequencer

Overview:
Controller that sequences a serial-in/serial-out shift datapath for transmitting parallel words as a serial bit stream.
- Accepts a WIDTH-bit word over a valid/ready handshake and loads it into an internal shift register.
- Shifts the word out LSB first, holding each bit for DIV clocks, and reports completion.
- Sits between a parallel producer and any downstream serial consumer or shift-register chain.

Parameters:
WIDTH, 8, data word width in bits (>=2)
DIV, 1, clocks per serial bit (>=1); divider counter width max(1,$clog2(DIV))

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low
in_data  input  WIDTH  parallel word to transmit
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial data, LSB first
ser_en  output  1  one-cycle strobe on the first clock of each bit period
busy  output  1  frame in progress (SHIFT, PARITY or DONE)
done  output  1  one-cycle pulse after the last bit period

Behaviour:
- One clock domain: clk; rst is asynchronous and active-low.
- Reset (rst=0): state=IDLE, shreg=0, bit_cnt=0, div_cnt=0. Outputs: in_ready=1 once released, ser_out=0, ser_en=0, busy=0, done=0.
- All outputs are registered or decoded from state only; there is no combinational path from in_valid to any output.
- States: IDLE, SHIFT, PARITY (only with the optional feature), DONE.
- IDLE:
  - in_ready=1, ser_out=0.
  - On a clock edge with in_valid=1: shreg<=in_data, bit_cnt<=0, div_cnt<=0, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - ser_out=shreg[0].
  - ser_en=1 when div_cnt==0.
  - div_cnt increments each clock.
  - When div_cnt==DIV-1: div_cnt<=0, shreg shifts right by 1, bit_cnt++.
  - When bit_cnt==WIDTH-1 and div_cnt==DIV-1: go to PARITY if enabled, else DONE.
- DONE:
  - Lasts one cycle: done=1, ser_out=0.
  - Next state is IDLE.
- Latency and throughput:
  - Handshake accepted at edge N; bit0 is visible from cycle N+1.
  - Bit k is driven during cycles N+1+k*DIV .. N+(k+1)*DIV.
  - done is asserted in cycle N+1+WIDTH*DIV (+DIV with parity).
  - in_ready returns the following cycle.
  - Back-to-back throughput: one frame per WIDTH*DIV+2 cycles.
- in_ready is 0 in every non-IDLE state.
  - in_valid while busy is ignored; the producer holds the word.
  - Changes to in_data after acceptance have no effect.
- DIV=1: ser_en stays high for every bit cycle of the frame.
- Reset mid-frame: everything returns asynchronously to reset values. The frame is abandoned, no done pulse is generated, and ser_out=0 immediately.

Optional Feature:
Macro TX_PARITY_EN.
- Defined:
  - On load, the block also registers par = XOR of in_data (even parity).
  - After the MSB bit period, the PARITY state drives ser_out=par for DIV cycles, with ser_en on its first cycle, then goes to DONE.
  - Frame length becomes (WIDTH+1)*DIV.
- Undefined: no PARITY state, no par register; SHIFT goes directly to DONE.

Test Plan:
- WIDTH=8, DIV=1, reset low 2 cycles then high, send 0x0D with in_valid pulse.
  - ser_out = 1,0,1,1,0,0,0,0 on cycles 1..8 after accept, ser_en=1 on cycles 1..8.
  - done=1 on cycle 9, in_ready=1 on cycle 10, busy=1 on cycles 1..9.
- DIV=3, send 0xA5.
  - Each bit held 3 cycles, pattern 1,0,1,0,0,1,0,1.
  - ser_en high only on cycles 1,4,7,...,22; done on cycle 25.
- Back-to-back: in_valid held high with 0x01 then 0x80.
  - Second accept occurs on the cycle after done.
  - in_data changed mid-frame does not alter the serial output.
  - Gap between frames is exactly 2 cycles (done + accept).
- Reset asserted at the 4th bit of 0xFF.
  - Outputs return to reset values immediately, no done pulse.
  - After release, sending 0x03 transmits cleanly.
- in_valid=1 with 0x55 while busy on 0x0F: ignored, in_ready=0, 0x0F completes, then 0x55 is accepted.
- TX_PARITY_EN defined, DIV=1, send 0x0D: ser_out = 1,0,1,1,0,0,0,0 then parity 1, done on cycle 10.
